// File: rtl/pwm_w_int_s_axi_regs.sv
// pwm_w_int_s_axi_regs: AXI4-Lite slave with four 32-bit registers driving a
// PWM counter and a level interrupt raised on every period wrap.
//   0x0 CTRL   [0]=pwm_en [1]=irq_en
//   0x4 PERIOD [CNT_WIDTH-1:0]
//   0x8 DUTY   [CNT_WIDTH-1:0]
//   0xC STATUS [0]=irq_pending, write-1-to-clear
// Optional build macro PWM_W_INT_SHADOW_EN: PERIOD/DUTY writes land in shadow
// registers that are copied to the active compare values on a wrap (or at once
// while the counter is stopped), so a running waveform never glitches.
module pwm_w_int_s_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            pwm_out,
  output logic                            irq
);

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}                      r_state_e;

  // Write channel state
  w_state_e       w_state_q;
  logic           awready_q, wready_q, bvalid_q;
  logic [1:0]     awaddr_q;
  logic [31:0]    wdata_q;
  logic [3:0]     wstrb_q;

  // Read channel state
  r_state_e       r_state_q;
  logic           arready_q, rvalid_q;
  logic [31:0]    rdata_q;

  // Register file and PWM datapath
  logic [1:0]           ctrl_q, ctrl_d;
  logic [CNT_WIDTH-1:0] period_reg_q, period_reg_d;
  logic [CNT_WIDTH-1:0] duty_reg_q, duty_reg_d;
  logic [CNT_WIDTH-1:0] period_act, duty_act;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 pwm_q, pwm_d;
  logic                 irq_pending_q, irq_pending_d;

  logic        aw_hs, w_hs, ar_hs, wr_commit, w1c, running, wrap;
  logic [1:0]  wr_sel;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [31:0] rd_mux;
  logic        unused_ok;

  assign aw_hs = awready_q & S_AXI_AWVALID;
  assign w_hs  = wready_q  & S_AXI_WVALID;
  assign ar_hs = arready_q & S_AXI_ARVALID;

  // The register write fires on the cycle the second half of the pair arrives.
  assign wr_commit = ((w_state_q == W_IDLE)    & aw_hs & w_hs) |
                     ((w_state_q == W_HAVE_AW) & w_hs) |
                     ((w_state_q == W_HAVE_W)  & aw_hs);
  assign wr_sel  = aw_hs ? S_AXI_AWADDR[3:2] : awaddr_q;
  assign wr_data = w_hs  ? S_AXI_WDATA       : wdata_q;
  assign wr_strb = w_hs  ? S_AXI_WSTRB       : wstrb_q;

  // Protection bits and the byte-lane address bits carry no meaning here.
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                       S_AXI_ARADDR[1:0], wr_data};

  // Replace only the strobed bytes of a CNT_WIDTH-wide register.
  function automatic logic [CNT_WIDTH-1:0] merge_bytes(
    input logic [CNT_WIDTH-1:0] old_v,
    input logic [CNT_WIDTH-1:0] data,
    input logic [3:0]           strb
  );
    logic [CNT_WIDTH-1:0] v;
    v = old_v;
    for (int i = 0; i < CNT_WIDTH; i++) begin
      if (strb[i/8]) v[i] = data[i];
    end
    return v;
  endfunction

  // Write FSM: ready pulses, address/data capture, response hold.
  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      awready_q <= !awready_q && S_AXI_AWVALID &&
                   (w_state_q == W_IDLE || w_state_q == W_HAVE_W);
      wready_q  <= !wready_q && S_AXI_WVALID &&
                   (w_state_q == W_IDLE || w_state_q == W_HAVE_AW);
      if (aw_hs) awaddr_q <= S_AXI_AWADDR[3:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      case (w_state_q)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            w_state_q <= W_RESP;
            bvalid_q  <= 1'b1;
          end else if (aw_hs) begin
            w_state_q <= W_HAVE_AW;
          end else if (w_hs) begin
            w_state_q <= W_HAVE_W;
          end
        end
        W_HAVE_AW: if (w_hs) begin
          w_state_q <= W_RESP;
          bvalid_q  <= 1'b1;
        end
        W_HAVE_W: if (aw_hs) begin
          w_state_q <= W_RESP;
          bvalid_q  <= 1'b1;
        end
        W_RESP: if (S_AXI_BREADY) begin
          w_state_q <= W_IDLE;
          bvalid_q  <= 1'b0;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Read-back view; PERIOD/DUTY show the AXI-written (shadow) values.
  always_comb begin
    rd_mux = '0;
    case (S_AXI_ARADDR[3:2])
      2'd0: rd_mux = {30'b0, ctrl_q};
      2'd1: rd_mux = 32'(period_reg_q);
      2'd2: rd_mux = 32'(duty_reg_q);
      2'd3: rd_mux = {31'b0, irq_pending_q};
      default: rd_mux = '0;
    endcase
  end

  // Read FSM: one-cycle ARREADY pulse, data registered and held until RREADY.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      arready_q <= !arready_q && S_AXI_ARVALID && (r_state_q == R_IDLE);
      case (r_state_q)
        R_IDLE: if (ar_hs) begin
          rdata_q   <= rd_mux;
          rvalid_q  <= 1'b1;
          r_state_q <= R_DATA;
        end
        R_DATA: if (S_AXI_RREADY) begin
          rvalid_q  <= 1'b0;
          r_state_q <= R_IDLE;
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // Next-state of registers, counter, PWM output and pending flag.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ctrl_d       = ctrl_q;
    period_reg_d = period_reg_q;
    duty_reg_d   = duty_reg_q;
    w1c          = 1'b0;
    if (wr_commit) begin
      case (wr_sel)
        2'd0: if (wr_strb[0]) ctrl_d = wr_data[1:0];
        2'd1: period_reg_d = merge_bytes(period_reg_q, wr_data[CNT_WIDTH-1:0], wr_strb);
        2'd2: duty_reg_d   = merge_bytes(duty_reg_q, wr_data[CNT_WIDTH-1:0], wr_strb);
        2'd3: w1c = wr_strb[0] & wr_data[0];
        default: ;
      endcase
    end
    running = ctrl_q[0] && (period_act != '0);
    wrap    = running && (cnt_q == period_act - CNT_WIDTH'(1));
    cnt_d   = (running && !wrap) ? cnt_q + CNT_WIDTH'(1) : '0;
    pwm_d   = running && (cnt_q < duty_act);
    // A wrap in the same cycle as a clear keeps the flag set.
    irq_pending_d = wrap | (irq_pending_q & ~w1c);
  end

  // Register file and PWM state.
  // NOTE: every register here has an async reset; there is no memory array to leave unreset.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ctrl_q        <= '0;
      period_reg_q  <= '0;
      duty_reg_q    <= '0;
      cnt_q         <= '0;
      pwm_q         <= 1'b0;
      irq_pending_q <= 1'b0;
    end else begin
      ctrl_q        <= ctrl_d;
      period_reg_q  <= period_reg_d;
      duty_reg_q    <= duty_reg_d;
      cnt_q         <= cnt_d;
      pwm_q         <= pwm_d;
      irq_pending_q <= irq_pending_d;
    end
  end

`ifdef PWM_W_INT_SHADOW_EN
  logic [CNT_WIDTH-1:0] period_act_q, duty_act_q;

  // Active compare values follow the shadows only at a period boundary or while stopped.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      period_act_q <= '0;
      duty_act_q   <= '0;
    end else if (wrap || !running) begin
      period_act_q <= period_reg_q;
      duty_act_q   <= duty_reg_q;
    end
  end

  assign period_act = period_act_q;
  assign duty_act   = duty_act_q;
`else
  // Compare values track the registers directly; a write may cut or stretch the current period.
  assign period_act = period_reg_q;
  assign duty_act   = duty_reg_q;
`endif

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign pwm_out       = pwm_q;
  assign irq           = irq_pending_q & ctrl_q[1];

endmodule

// File: tb/tb_pwm_w_int_s_axi_regs.sv
// Testbench for pwm_w_int_s_axi_regs: directed scenarios with literal
// expectations plus randomized AXI traffic, all outputs compared every cycle
// against a behavioural model of the register map and PWM rules.
module tb_pwm_w_int_s_axi_regs;
  localparam int CW = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, pwm_out, irq;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pwm_w_int_s_axi_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .CNT_WIDTH(CW)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .pwm_out(pwm_out), .irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [1:0]    m_ctrl = '0;
  logic [CW-1:0] m_period = '0, m_duty = '0, m_per_act = '0, m_duty_act = '0, m_cnt = '0;
  bit            m_pwm = 0, m_pend = 0;
  logic [31:0]   m_rd_exp = '0;
  bit            m_aw_got = 0, m_w_got = 0;
  logic [3:0]    m_awaddr = '0, m_wstrb = '0;
  logic [31:0]   m_wdata = '0;

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return {30'b0, m_ctrl};
      2'd1:    return {16'b0, m_period};
      2'd2:    return {16'b0, m_duty};
      default: return {31'b0, m_pend};
    endcase
  endfunction

  function automatic logic [CW-1:0] apply_strb(input logic [CW-1:0] old_v,
                                               input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = {16'b0, old_v};
    if (s[0]) v[7:0]  = d[7:0];
    if (s[1]) v[15:8] = d[15:8];
    return v[CW-1:0];
  endfunction

  // Compare process: sample mid-cycle, check outputs, then advance the model one clock.
  initial begin
    bit aw_now, w_now, commit, run, wrp, w1c;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_ctrl = '0; m_period = '0; m_duty = '0; m_per_act = '0; m_duty_act = '0;
        m_cnt = '0; m_pwm = 0; m_pend = 0; m_aw_got = 0; m_w_got = 0;
        check("reset_ctl_outputs", {25'b0, awready, wready, bvalid, arready, rvalid, pwm_out, irq}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
      end else begin
        check("pwm_out", {31'b0, pwm_out}, {31'b0, m_pwm});
        check("irq", {31'b0, irq}, {31'b0, m_pend & m_ctrl[1]});
        if (rvalid) begin
          check("rdata", rdata, m_rd_exp);
          check("rresp", {30'b0, rresp}, 32'h0);
        end
        if (bvalid) check("bresp", {30'b0, bresp}, 32'h0);

        if (arvalid && arready) m_rd_exp = model_read(araddr);
        aw_now = awvalid && awready;
        w_now  = wvalid && wready;
        if (aw_now) m_awaddr = awaddr;
        if (w_now) begin m_wdata = wdata; m_wstrb = wstrb; end
        commit   = (m_aw_got || aw_now) && (m_w_got || w_now);
        m_aw_got = (m_aw_got || aw_now) && !commit;
        m_w_got  = (m_w_got || w_now) && !commit;

        run   = m_ctrl[0] && (m_per_act != 0);
        wrp   = run && (int'(m_cnt) == int'(m_per_act) - 1);
        m_pwm = run && (m_cnt < m_duty_act);
        m_cnt = (run && !wrp) ? m_cnt + 1'b1 : '0;
        w1c   = commit && (m_awaddr[3:2] == 2'd3) && m_wstrb[0] && m_wdata[0];
        m_pend = wrp || (m_pend && !w1c);
`ifdef PWM_W_INT_SHADOW_EN
        if (wrp || !run) begin m_per_act = m_period; m_duty_act = m_duty; end
`endif
        if (commit) begin
          case (m_awaddr[3:2])
            2'd0: if (m_wstrb[0]) m_ctrl = m_wdata[1:0];
            2'd1: m_period = apply_strb(m_period, m_wdata, m_wstrb);
            2'd2: m_duty   = apply_strb(m_duty, m_wdata, m_wstrb);
            default: ;
          endcase
        end
`ifndef PWM_W_INT_SHADOW_EN
        m_per_act = m_period; m_duty_act = m_duty;
`endif
      end
    end
  end

  // ---------------- bus-master tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly = 0, input int w_dly = 0, input int b_dly = 0);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w, seen = 0;
    int cyc = 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && cyc < 50) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      @(negedge clk);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      tick();
      aw_done |= hs_aw;
      w_done  |= hs_w;
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    if (!(aw_done && w_done)) check("write_addr_data_timeout", 32'h0, 32'h1);
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clk);
      check("bvalid_hold_no_accept", {29'b0, bvalid, awready, wready}, 32'h4);
      tick();
    end
    bready = 1;
    cyc = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      seen = bvalid;
      tick();
      cyc++;
    end
    bready = 0;
    if (!seen) check("write_resp_timeout", 32'h0, 32'h1);
    @(negedge clk);
    check("bvalid_single", {31'b0, bvalid}, 32'h0);
    tick();
  endtask

  task automatic axi_read(input logic [3:0] a, input int r_dly, output logic [31:0] d);
    bit hs = 0, got = 0;
    int cyc = 0;
    d = 'x;
    araddr = a; arvalid = 1;
    while (!hs && cyc < 50) begin
      @(negedge clk);
      hs = arvalid && arready;
      if (hs) check("rvalid_not_early", {31'b0, rvalid}, 32'h0);
      tick();
      cyc++;
    end
    arvalid = 0;
    if (!hs) check("read_addr_timeout", 32'h0, 32'h1);
    repeat (r_dly) tick();
    rready = 1;
    cyc = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      got = rvalid;
      if (got) d = rdata;
      tick();
      cyc++;
    end
    rready = 0;
    if (!got) check("read_data_timeout", 32'h0, 32'h1);
  endtask

  task automatic read_expect(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(a, 0, d);
    check(name, d, exp);
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pwm_out) hi++;
      tick();
    end
  endtask

  task automatic irq_expect(input string name, input bit exp);
    @(negedge clk);
    check(name, {31'b0, irq}, {31'b0, exp});
    tick();
  endtask

  // Runaway guard: stop with a failure line rather than hang.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int hi;
    bit seen;
    logic [31:0] d;
    repeat (3) tick();
    rst_n = 1;
    tick();

    // Reset values
    read_expect("reset_ctrl",   4'h0, 32'h0);
    read_expect("reset_period", 4'h4, 32'h0);
    read_expect("reset_duty",   4'h8, 32'h0);
    read_expect("reset_status", 4'hC, 32'h0);

    // Basic programming and read-back
    axi_write(4'h4, 32'h0000_000A, 4'hF);
    axi_write(4'h8, 32'h0000_0003, 4'hF);
    axi_write(4'h0, 32'h0000_0003, 4'hF);
    read_expect("rb_period", 4'h4, 32'hA);
    read_expect("rb_duty",   4'h8, 32'h3);
    read_expect("rb_ctrl",   4'h0, 32'h3);

    // 3-of-10 duty cycle in steady state; wrap must have raised the interrupt
    repeat (12) tick();
    count_high(100, hi);
    check("duty_3_of_10", hi, 30);
    irq_expect("irq_after_wrap", 1);

    // Stopping keeps pending; W1C with 0 does nothing, with 1 clears
    axi_write(4'h0, 32'h0000_0002, 4'hF);
    irq_expect("irq_retained_after_stop", 1);
    axi_write(4'hC, 32'h0000_0000, 4'hF);
    irq_expect("w1c_zero_no_effect", 1);
    axi_write(4'hC, 32'h0000_0001, 4'hF);
    irq_expect("w1c_clears", 0);
    read_expect("status_cleared", 4'hC, 32'h0);

    // PERIOD=1: wraps every cycle, so set beats the clear
    axi_write(4'h4, 32'h1, 4'hF);
    axi_write(4'h8, 32'h1, 4'hF);
    axi_write(4'h0, 32'h3, 4'hF);
    count_high(20, hi);
    check("period1_pwm_const", hi, 20);
    axi_write(4'hC, 32'h1, 4'hF);
    irq_expect("set_wins_over_clear", 1);
    read_expect("status_set_wins", 4'hC, 32'h1);

    // DUTY >= PERIOD: constant high
    axi_write(4'h8, 32'h0000_FFFF, 4'hF);
    axi_write(4'h4, 32'h0000_0005, 4'hF);
    repeat (3) tick();
    count_high(50, hi);
    check("duty_ge_period_const1", hi, 50);

    // PERIOD=0: stopped, no new interrupt
    axi_write(4'h4, 32'h0, 4'hF);
    axi_write(4'hC, 32'h1, 4'hF);
    count_high(30, hi);
    check("period0_pwm_low", hi, 0);
    read_expect("period0_no_irq", 4'hC, 32'h0);

    // irq_en=0 masks but does not clear
    axi_write(4'h4, 32'h4, 4'hF);
    axi_write(4'h8, 32'h2, 4'hF);
    axi_write(4'h0, 32'h1, 4'hF);
    repeat (10) tick();
    irq_expect("irq_masked", 0);
    read_expect("masked_status_pending", 4'hC, 32'h1);
    axi_write(4'h0, 32'h3, 4'hF);
    irq_expect("irq_unmasked", 1);

    // Handshake ordering and delayed BREADY
    axi_write(4'h0, 32'h0, 4'hF);
    axi_write(4'h8, 32'h5, 4'hF, 3, 0, 5);
    read_expect("w_before_aw", 4'h8, 32'h5);
    axi_write(4'h8, 32'h6, 4'hF, 0, 2, 0);
    read_expect("aw_before_w", 4'h8, 32'h6);

    // Byte strobes and unimplemented upper bits
    axi_write(4'h4, 32'h0000_0004, 4'hF);
    axi_write(4'h4, 32'h1234_5678, 4'b0010);
    read_expect("strobe_byte1_only", 4'h4, 32'h0000_5604);
    axi_write(4'h4, 32'hFFFF_0007, 4'hF);
    read_expect("period_upper_read0", 4'h4, 32'h0000_0007);
    axi_write(4'h0, 32'hFFFF_FFFC, 4'hF);
    read_expect("ctrl_upper_read0", 4'h0, 32'h0);
    axi_write(4'hC, 32'h1, 4'b1110);
    read_expect("w1c_needs_strb0", 4'hC, 32'h1);
    axi_write(4'hC, 32'h1, 4'b0001);
    read_expect("w1c_strb0", 4'hC, 32'h0);

    // Reset while a write response is pending
    awaddr = 4'h4; wdata = 32'h7; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bvalid;
      if (!seen) begin
        if (awvalid && awready) begin tick(); awvalid = 0; end
        else tick();
        if (!awvalid && wvalid && !wready && i > 2) wvalid = wvalid;
      end
      if (wvalid && wready) wvalid = wvalid;
    end
    check("bvalid_before_reset", {31'b0, seen}, 32'h1);
    awvalid = 0; wvalid = 0;
    #2 rst_n = 0;
    #1;
    check("async_reset_outputs", {25'b0, awready, wready, bvalid, arready, rvalid, pwm_out, irq}, 32'h0);
    check("async_reset_rdata", rdata, 32'h0);
    tick(); tick();
    rst_n = 1;
    tick();
    read_expect("post_reset_period", 4'h4, 32'h0);
    read_expect("post_reset_ctrl",   4'h0, 32'h0);
    read_expect("post_reset_status", 4'hC, 32'h0);

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 80; i++) begin
      logic [3:0]  a, ra;
      logic [31:0] dv;
      logic [3:0]  sv;
      int kind;
      kind = $urandom_range(0, 3);
      a  = 4'($urandom_range(0, 3) * 4);
      ra = 4'($urandom_range(0, 3) * 4);
      case (a)
        4'h4, 4'h8: dv = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 12));
        default:    dv = $urandom;
      endcase
      sv = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
      case (kind)
        0: axi_write(a, dv, sv, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        1: axi_read(ra, $urandom_range(0, 3), d);
        2: fork
             axi_write(a, dv, sv, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
             axi_read(ra, $urandom_range(0, 2), d);
           join
        default: repeat ($urandom_range(1, 15)) tick();
      endcase
    end
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
